// File: rtl/circle_draw_ctrl.sv
// rtl/circle_draw_ctrl.sv - sequencer for the VGA clear pass and midpoint-circle draw
module circle_draw_ctrl #(
  parameter logic       CLEAR_FIRST   = 1'b1,
  parameter logic [2:0] CLEAR_COLOUR  = 3'b000,
  parameter logic [2:0] CIRCLE_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       xdone,
  input  logic       ydone,
  input  logic       cdone,
  output logic       initx,
  output logic       inity,
  output logic       initc,
  output logic       loadx,
  output logic       loady,
  output logic       loadc,
  output logic       flagc,
  output logic [4:0] selx,
  output logic [4:0] sely,
  output logic       plot,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_CLR_INIT  = 3'd1;
  localparam logic [2:0] S_CLR_PLOT  = 3'd2;
  localparam logic [2:0] S_CIR_INIT  = 3'd3;
  localparam logic [2:0] S_CIR_OCT   = 3'd4;
  localparam logic [2:0] S_CIR_STEP  = 3'd5;
  localparam logic [2:0] S_CIR_CHECK = 3'd6;
  localparam logic [2:0] S_DONE      = 3'd7;

  logic [2:0] state_q, state_d;
  logic [2:0] k_q, k_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      k_q     <= 3'd0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    initx   = 1'b0;
    inity   = 1'b0;
    initc   = 1'b0;
    loadx   = 1'b0;
    loady   = 1'b0;
    loadc   = 1'b0;
    flagc   = 1'b0;
    selx    = 5'b10000;
    sely    = 5'b10000;
    plot    = 1'b0;
    colour  = 3'b000;
    busy    = 1'b1;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_d = CLEAR_FIRST ? S_CLR_INIT : S_CIR_INIT;
      end
      S_CLR_INIT: begin
        initx   = 1'b1;
        inity   = 1'b1;
        loadx   = 1'b1;
        loady   = 1'b1;
        state_d = S_CLR_PLOT;
      end
      S_CLR_PLOT: begin
        // column-major sweep: y wraps to 0 and x advances at the bottom of each column
        plot   = 1'b1;
        colour = CLEAR_COLOUR;
        if (!ydone) begin
          loady = 1'b1;
        end else if (!xdone) begin
          loady = 1'b1;
          inity = 1'b1;
          loadx = 1'b1;
        end else begin
          state_d = S_CIR_INIT;
        end
      end
      S_CIR_INIT: begin
        flagc   = 1'b1;
        initx   = 1'b1;
        inity   = 1'b1;
        initc   = 1'b1;
        loadx   = 1'b1;
        loady   = 1'b1;
        loadc   = 1'b1;
        k_d     = 3'd0;
        state_d = S_CIR_OCT;
      end
      S_CIR_OCT: begin
        plot   = 1'b1;
        colour = CIRCLE_COLOUR;
        k_d    = k_q + 3'd1;
        case (k_q)
          3'd0:    begin selx = 5'b00001; sely = 5'b00001; end
          3'd1:    begin selx = 5'b00010; sely = 5'b00010; end
          3'd2:    begin selx = 5'b00100; sely = 5'b00001; end
          3'd3:    begin selx = 5'b01000; sely = 5'b00010; end
          3'd4:    begin selx = 5'b00100; sely = 5'b00100; end
          3'd5:    begin selx = 5'b01000; sely = 5'b01000; end
          3'd6:    begin selx = 5'b00001; sely = 5'b00100; end
          default: begin selx = 5'b00010; sely = 5'b01000; end
        endcase
        if (k_q == 3'd7) state_d = S_CIR_STEP;
      end
      S_CIR_STEP: begin
        flagc   = 1'b1;
        loadx   = 1'b1;
        loady   = 1'b1;
        loadc   = 1'b1;
        state_d = S_CIR_CHECK;
      end
      S_CIR_CHECK: begin
        // one settle cycle so cdone reflects the freshly stepped x/y
        k_d     = 3'd0;
        state_d = cdone ? S_CIR_OCT : S_DONE;
      end
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_circle_draw_ctrl.sv
// tb/tb_circle_draw_ctrl.sv - scoreboard bench for circle_draw_ctrl with a behavioural datapath
module tb_circle_draw_ctrl;

  localparam int R  = 40;
  localparam int CX = 80;
  localparam int CY = 40;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] start_w;
  logic [1:0] xdone_w, ydone_w, cdone_w;
  logic [1:0] initx_w, inity_w, initc_w, loadx_w, loady_w, loadc_w, flagc_w;
  logic [1:0] plot_w, busy_w, done_w;
  logic [4:0] selx_w [2];
  logic [4:0] sely_w [2];
  logic [2:0] colour_w [2];

  int  x_m [2];
  int  y_m [2];
  int  crit_m [2];
  bit  force0;
  bit  sb_en;
  int  exp_q [$];
  int  n_checks, n_pass;
  int  cyc, plot_cnt, last_plot_cyc, pass_base;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  circle_draw_ctrl #(.CLEAR_FIRST(1'b1), .CLEAR_COLOUR(3'b000), .CIRCLE_COLOUR(3'b010)) u0 (
    .clk(clk), .reset(reset), .start(start_w[0]),
    .xdone(xdone_w[0]), .ydone(ydone_w[0]), .cdone(cdone_w[0]),
    .initx(initx_w[0]), .inity(inity_w[0]), .initc(initc_w[0]),
    .loadx(loadx_w[0]), .loady(loady_w[0]), .loadc(loadc_w[0]), .flagc(flagc_w[0]),
    .selx(selx_w[0]), .sely(sely_w[0]), .plot(plot_w[0]), .colour(colour_w[0]),
    .busy(busy_w[0]), .done(done_w[0])
  );

  circle_draw_ctrl #(.CLEAR_FIRST(1'b0), .CLEAR_COLOUR(3'b000), .CIRCLE_COLOUR(3'b010)) u1 (
    .clk(clk), .reset(reset), .start(start_w[1]),
    .xdone(xdone_w[1]), .ydone(ydone_w[1]), .cdone(cdone_w[1]),
    .initx(initx_w[1]), .inity(inity_w[1]), .initc(initc_w[1]),
    .loadx(loadx_w[1]), .loady(loady_w[1]), .loadc(loadc_w[1]), .flagc(flagc_w[1]),
    .selx(selx_w[1]), .sely(sely_w[1]), .plot(plot_w[1]), .colour(colour_w[1]),
    .busy(busy_w[1]), .done(done_w[1])
  );

  // behavioural datapath: clear-mode counters and midpoint x/y/crit registers
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (loadx_w[i])
        x_m[i] <= initx_w[i] ? (flagc_w[i] ? R : 0)
                             : (flagc_w[i] ? ((crit_m[i] > 0) ? x_m[i] - 1 : x_m[i]) : x_m[i] + 1);
      if (loady_w[i])
        y_m[i] <= inity_w[i] ? 0 : y_m[i] + 1;
      if (loadc_w[i])
        crit_m[i] <= initc_w[i] ? 1 - R
                   : ((crit_m[i] > 0) ? crit_m[i] + 2 * ((y_m[i] + 1) - (x_m[i] - 1)) + 1
                                      : crit_m[i] + 2 * (y_m[i] + 1) + 1);
    end
  end

  always_comb begin
    xdone_w = 2'b00;
    ydone_w = 2'b00;
    cdone_w = 2'b00;
    for (int i = 0; i < 2; i++) begin
      xdone_w[i] = (x_m[i] == 159);
      ydone_w[i] = (y_m[i] == 119);
      cdone_w[i] = (y_m[i] <= x_m[i]);
    end
    if (force0) cdone_w[0] = 1'b0;
  end

  function automatic int enc(input int x, input int y, input int c);
    return x * 65536 + y * 16 + c;
  endfunction

  function automatic int pix_x(input logic [4:0] s, input int x, input int y);
    case (s)
      5'b00001: return CX + x;
      5'b00010: return CX + y;
      5'b00100: return CX - x;
      5'b01000: return CX - y;
      default:  return x;
    endcase
  endfunction

  function automatic int pix_y(input logic [4:0] s, input int x, input int y);
    case (s)
      5'b00001: return CY + y;
      5'b00010: return CY + x;
      5'b00100: return CY - y;
      5'b01000: return CY - x;
      default:  return y;
    endcase
  endfunction

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endfunction

  function automatic int strobes(input int i);
    return int'({initx_w[i], inity_w[i], initc_w[i], loadx_w[i], loady_w[i], loadc_w[i], flagc_w[i]});
  endfunction

  task automatic push_clear();
    for (int x = 0; x < 160; x++)
      for (int y = 0; y < 120; y++)
        exp_q.push_back(enc(x, y, 0));
  endtask

  task automatic push_circle(input int max_it, output int n_it);
    int x, y, c;
    x = R; y = 0; c = 1 - R; n_it = 0;
    do begin
      exp_q.push_back(enc(CX + x, CY + y, 2));
      exp_q.push_back(enc(CX + y, CY + x, 2));
      exp_q.push_back(enc(CX - x, CY + y, 2));
      exp_q.push_back(enc(CX - y, CY + x, 2));
      exp_q.push_back(enc(CX - x, CY - y, 2));
      exp_q.push_back(enc(CX - y, CY - x, 2));
      exp_q.push_back(enc(CX + x, CY - y, 2));
      exp_q.push_back(enc(CX + y, CY - x, 2));
      n_it++;
      y++;
      if (c <= 0) c = c + 2 * y + 1;
      else begin
        x--;
        c = c + 2 * (y - x) + 1;
      end
    end while (y <= x && n_it < max_it);
  endtask

  // monitor: every plot from u0 is matched against the head of the expected queue
  always @(negedge clk) begin
    if (sb_en) begin
      if (initc_w[0])
        chk("clear_plots_before_cir_init", plot_cnt - pass_base, 19200);
      if (plot_w[0]) begin
        plot_cnt++;
        last_plot_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_plot: got pixel 0x%0h expected none",
                   enc(pix_x(selx_w[0], x_m[0], y_m[0]), pix_y(sely_w[0], x_m[0], y_m[0]), int'(colour_w[0])));
        end else begin
          chk("pixel", enc(pix_x(selx_w[0], x_m[0], y_m[0]), pix_y(sely_w[0], x_m[0], y_m[0]),
                           int'(colour_w[0])), exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_done(input int i, input int budget, input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_w[i] && n < budget);
    chk(name, int'(done_w[i]), 1);
  endtask

  initial begin
    int it, expect_circle;
    reset = 1'b1; start_w = 2'b00; force0 = 1'b0; sb_en = 1'b0;
    n_checks = 0; n_pass = 0; cyc = 0; plot_cnt = 0; last_plot_cyc = 0; pass_base = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset mid-CLR_PLOT
    @(negedge clk); start_w[0] = 1'b1;
    @(negedge clk); start_w[0] = 1'b0;
    chk("clr_init_strobes", strobes(0), 7'b1101100);
    chk("clr_init_busy", int'(busy_w[0]), 1);
    @(negedge clk);
    chk("clr_plot_active", int'(plot_w[0]), 1);
    #2 reset = 1'b1;
    #1;
    chk("reset_plot", int'(plot_w[0]), 0);
    chk("reset_strobes", strobes(0), 0);
    chk("reset_sel", int'({selx_w[0], sely_w[0]}), 10'b1000010000);
    chk("reset_busy_done", int'({busy_w[0], done_w[0], colour_w[0]}), 0);
    @(negedge clk); reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_reset", int'({busy_w[0], plot_w[0], done_w[0]}), 0);

    // no-clear variant goes straight to the circle
    start_w[1] = 1'b1;
    @(negedge clk); start_w[1] = 1'b0;
    chk("noclear_cir_init_strobes", strobes(1), 7'b1111111);
    @(negedge clk);
    chk("noclear_first_plot", int'({plot_w[1], selx_w[1], sely_w[1], colour_w[1]}),
        int'({1'b1, 5'b00001, 5'b00001, 3'b010}));
    wait_done(1, 1000, "noclear_done");

    // full clear + circle pass
    push_clear();
    push_circle(1000, it);
    expect_circle = 8 * it;
    pass_base = plot_cnt;
    sb_en = 1'b1;
    start_w[0] = 1'b1;
    @(negedge clk); start_w[0] = 1'b0;
    chk("pass_clr_init_strobes", strobes(0), 7'b1101100);
    wait_done(0, 25000, "full_done");
    chk("full_plot_count", plot_cnt - pass_base, 19200 + expect_circle);
    chk("full_queue_empty", exp_q.size(), 0);
    chk("full_done_latency", cyc - last_plot_cyc, 3);
    chk("full_busy_in_done", int'(busy_w[0]), 0);
    @(negedge clk);
    chk("full_back_to_idle", int'({busy_w[0], done_w[0]}), 0);

    // forced termination with start held through DONE
    force0 = 1'b1;
    push_clear();
    push_circle(1, it);
    pass_base = plot_cnt;
    start_w[0] = 1'b1;
    wait_done(0, 25000, "forced_done");
    chk("forced_plot_count", plot_cnt - pass_base, 19208);
    chk("forced_done_latency", cyc - last_plot_cyc, 3);
    repeat (5) @(negedge clk);
    chk("held_start_stays_done", int'({busy_w[0], done_w[0]}), 1);
    chk("held_start_no_plots", plot_cnt - pass_base, 19208);
    start_w[0] = 1'b0;
    @(negedge clk);
    chk("drop_start_idle", int'({busy_w[0], done_w[0]}), 0);

    // restart, toggling start while busy
    push_clear();
    push_circle(1, it);
    pass_base = plot_cnt;
    start_w[0] = 1'b1;
    @(negedge clk);
    chk("restart_busy", int'(busy_w[0]), 1);
    for (int n = 0; n < 19000; n++) begin
      @(negedge clk);
      start_w[0] = ((n % 7) < 3);
    end
    start_w[0] = 1'b0;
    wait_done(0, 2000, "restart_done");
    chk("restart_plot_count", plot_cnt - pass_base, 19208);
    chk("restart_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
